// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard/forwarding bundle between the decode stage (master) and the
// hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int AW    = 5,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    localparam int SW = $clog2(DEPTH + 1);

    logic          id_valid;
    logic [AW-1:0] id_rn;
    logic [AW-1:0] id_rm;
    logic          id_rn_used;
    logic          id_rm_used;
    logic [AW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_is_load;
    logic          flush;

    logic [SW-1:0]    fwd_a_sel;
    logic [SW-1:0]    fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
               id_rd, id_regwrite, id_is_load, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
               id_rd, id_regwrite, id_is_load, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Depth-generic forwarding/load-use controller beside ID: tracks in-flight
// destination registers in a shift register, one slot per downstream stage.
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_AVAIL = 2,
    parameter int ZERO_REG   = 31,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    localparam int          SW = $clog2(DEPTH + 1);
    localparam int unsigned LA = LOAD_AVAIL;
    localparam int unsigned DU = DEPTH;

    logic          r_v  [1:DEPTH];
    logic [AW-1:0] r_rd [1:DEPTH];
    logic          r_rw [1:DEPTH];
    logic          r_ld [1:DEPTH];
    logic [CNT_W-1:0] r_cnt;

    logic [SW-1:0] w_a_sel;
    logic [SW-1:0] w_b_sel;
    logic          w_a_haz;
    logic          w_b_haz;
    logic          w_stall;
    logic          w_issue;

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        w_a_haz = 1'b0;
        w_b_haz = 1'b0;
        for (int unsigned k = DU; k >= 1; k--) begin
            if (bus.id_rn_used && r_v[k] && r_rw[k] && (r_rd[k] == bus.id_rn) &&
                (bus.id_rn != AW'(ZERO_REG))) begin
                w_a_sel = SW'(k);
                w_a_haz = r_ld[k] && (k < LA);
            end
            if (bus.id_rm_used && r_v[k] && r_rw[k] && (r_rd[k] == bus.id_rm) &&
                (bus.id_rm != AW'(ZERO_REG))) begin
                w_b_sel = SW'(k);
                w_b_haz = r_ld[k] && (k < LA);
            end
        end
    end

    assign w_stall = bus.id_valid && !bus.flush && (w_a_haz || w_b_haz);
    assign w_issue = bus.id_valid && !bus.flush && !w_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 1; k <= DU; k++) begin
                r_v[k]  <= 1'b0;
                r_rd[k] <= '0;
                r_rw[k] <= 1'b0;
                r_ld[k] <= 1'b0;
            end
            r_cnt <= '0;
        end else begin
            for (int unsigned k = 2; k <= DU; k++) begin
                r_v[k]  <= r_v[k-1];
                r_rd[k] <= r_rd[k-1];
                r_rw[k] <= r_rw[k-1];
                r_ld[k] <= r_ld[k-1];
            end
            r_v[1]  <= w_issue;
            r_rd[1] <= w_issue ? bus.id_rd : '0;
            r_rw[1] <= w_issue && bus.id_regwrite;
            r_ld[1] <= w_issue && bus.id_is_load;
            if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.fwd_a_sel = w_a_sel;
    assign bus.fwd_b_sel = w_b_sel;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_cnt;
endmodule
